// File: rtl/pck_inj_scheduler_pkg.sv
// Shared types and constants for the packet-injector scheduler.
//
// Contents:
//   PKG_EAW, PKG_V, PKG_DATAW, PKG_PCK_SIZW : default field widths. The
//       scheduler's EAw/V/DATAw/PCK_SIZw parameters default to these and
//       must stay equal to them, because sched_desc_t is sized from them.
//   STATS_CNT_W  : width of each statistics counter (PCK_SCHED_STATS_EN build).
//   sched_desc_t : one latched packet descriptor (dest, size, data, vc).
//   sat_inc()    : saturating increment for the statistics counters.
package pck_inj_scheduler_pkg;

    localparam int PKG_EAW      = 4;
    localparam int PKG_V        = 2;
    localparam int PKG_DATAW    = 128;
    localparam int PKG_PCK_SIZW = 5;

    localparam int STATS_CNT_W  = 16;

    typedef struct packed {
        logic [PKG_EAW-1:0]      dest;
        logic [PKG_PCK_SIZW-1:0] size;
        logic [PKG_DATAW-1:0]    data;
        logic [PKG_V-1:0]        vc;
    } sched_desc_t;

    // Holds at all-ones instead of wrapping to zero.
    function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] v);
        return (&v) ? v : v + STATS_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pck_inj_scheduler_if.sv
// Control-side interface between the scheduler and one packet_injector.
//
// Signals:
//   inj_ready     : injector ready per VC (injector -> scheduler)
//   inj_pck_wr    : single-cycle packet write strobe
//   inj_endp_addr : destination endpoint address
//   inj_size      : packet size in flits
//   inj_data      : packet payload
//   inj_vc        : one-hot VC select
// Modports:
//   master : scheduler side (drives the strobe and descriptor fields)
//   slave  : injector side
interface pck_inj_scheduler_if
    import pck_inj_scheduler_pkg::*;
#(
    parameter int V        = PKG_V,
    parameter int EAw      = PKG_EAW,
    parameter int DATAw    = PKG_DATAW,
    parameter int PCK_SIZw = PKG_PCK_SIZW
) ();

    logic [V-1:0]        inj_ready;
    logic                inj_pck_wr;
    logic [EAw-1:0]      inj_endp_addr;
    logic [PCK_SIZw-1:0] inj_size;
    logic [DATAw-1:0]    inj_data;
    logic [V-1:0]        inj_vc;

    modport master (
        input  inj_ready,
        output inj_pck_wr, inj_endp_addr, inj_size, inj_data, inj_vc
    );

    modport slave (
        output inj_ready,
        input  inj_pck_wr, inj_endp_addr, inj_size, inj_data, inj_vc
    );

endinterface

// File: rtl/pck_inj_scheduler_rr_arbiter.sv
// Round-robin arbiter used by pck_inj_scheduler.
//
// Ports:
//   clk, reset : clock, asynchronous active-low reset (pointer returns to 0)
//   req        : per-requester eligibility
//   adv        : move the pointer past adv_idx this cycle
//   adv_idx    : index that was just served
//   any        : at least one request is present
//   gnt_idx    : first requesting index at or after the pointer, wrapping
module pck_sched_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          adv,
    input  logic [IW-1:0] adv_idx,
    output logic          any,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q, ptr_d;

    // Walk from the farthest offset back to the pointer so the last hit,
    // which is the one that sticks, is the closest one at or after ptr_q.
    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % N]) begin
                any     = 1'b1;
                gnt_idx = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = (adv_idx == IW'(N - 1)) ? '0 : adv_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pck_inj_scheduler.sv
// Shares one packet_injector control interface between NREQ requesters.
// Round-robin picks an eligible requester, the descriptor is latched, and a
// single-cycle write strobe is followed by a one-cycle gap. Malformed
// descriptors (vc not one-hot, size out of range) are acked with an error
// and never written.
//
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   req_valid     : requester i holds a descriptor
//   req_dest/size/data/vc : flattened descriptors, requester i at [i*W +: W]
//   req_ack       : one-cycle pulse, descriptor consumed
//   req_err       : one-cycle pulse alongside req_ack, descriptor rejected
//   inj           : injector control interface (master modport)
//   busy          : scheduler is not idle
// Optional (macro PCK_SCHED_STATS_EN):
//   sent_cnt      : per-requester saturating count of issued packets
//   reject_cnt    : saturating count of rejected descriptors
module pck_inj_scheduler
    import pck_inj_scheduler_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int V            = PKG_V,
    parameter int EAw          = PKG_EAW,
    parameter int DATAw        = PKG_DATAW,
    parameter int PCK_SIZw     = PKG_PCK_SIZW,
    parameter int MIN_PCK_SIZE = 3,
    parameter int MAX_PCK_SIZE = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*EAw-1:0]      req_dest,
    input  logic [NREQ*PCK_SIZw-1:0] req_size,
    input  logic [NREQ*DATAw-1:0]    req_data,
    input  logic [NREQ*V-1:0]        req_vc,
    output logic [NREQ-1:0]          req_ack,
    output logic [NREQ-1:0]          req_err,
    pck_inj_scheduler_if.master      inj,
    output logic                     busy
`ifdef PCK_SCHED_STATS_EN
    ,
    output logic [NREQ*STATS_CNT_W-1:0] sent_cnt,
    output logic [STATS_CNT_W-1:0]      reject_cnt
`endif
);

    localparam int GW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_REJECT = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    logic [1:0]      state_q, state_d;
    sched_desc_t     desc_q, desc_d;
    logic [GW-1:0]   gnt_q, gnt_d;

    logic [NREQ-1:0] bad;
    logic [NREQ-1:0] elig;
    logic            arb_any;
    logic [GW-1:0]   arb_idx;
    logic            adv;
    logic [NREQ-1:0] gnt_mask;

    // Malformed descriptors are eligible regardless of inj_ready so they are
    // flushed out with an error instead of blocking their requester forever.
    for (genvar i = 0; i < NREQ; i++) begin : g_req
        logic [V-1:0]        vc_w;
        logic [PCK_SIZw-1:0] size_w;
        assign vc_w    = req_vc[i*V +: V];
        assign size_w  = req_size[i*PCK_SIZw +: PCK_SIZw];
        assign bad[i]  = ($countones(vc_w) != 1) ||
                         (int'(size_w) < MIN_PCK_SIZE) ||
                         (int'(size_w) > MAX_PCK_SIZE);
        assign elig[i] = req_valid[i] && (bad[i] || |(vc_w & inj.inj_ready));
    end

    // Only IDLE consults the arbiter; the pointer moves on the ack cycle.
    assign adv = (state_q == S_ISSUE) || (state_q == S_REJECT);

    pck_sched_rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (elig),
        .adv     (adv),
        .adv_idx (gnt_q),
        .any     (arb_any),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        gnt_d   = gnt_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    desc_d.dest = req_dest[arb_idx*EAw +: EAw];
                    desc_d.size = req_size[arb_idx*PCK_SIZw +: PCK_SIZw];
                    desc_d.data = req_data[arb_idx*DATAw +: DATAw];
                    desc_d.vc   = req_vc[arb_idx*V +: V];
                    gnt_d       = arb_idx;
                    state_d     = bad[arb_idx] ? S_REJECT : S_ISSUE;
                end
            end
            S_ISSUE:  state_d = S_GAP;
            S_REJECT: state_d = S_IDLE;
            S_GAP:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            desc_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt_mask = {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
    assign req_ack  = adv ? gnt_mask : '0;
    assign req_err  = (state_q == S_REJECT) ? gnt_mask : '0;
    assign busy     = (state_q != S_IDLE);

    assign inj.inj_pck_wr    = (state_q == S_ISSUE);
    assign inj.inj_endp_addr = desc_q.dest;
    assign inj.inj_size      = desc_q.size;
    assign inj.inj_data      = desc_q.data;
    assign inj.inj_vc        = desc_q.vc;

`ifdef PCK_SCHED_STATS_EN
    logic [STATS_CNT_W-1:0] sent_q [NREQ];
    logic [STATS_CNT_W-1:0] sent_d [NREQ];
    logic [STATS_CNT_W-1:0] rej_q, rej_d;

    always_comb begin
        sent_d = sent_q;
        rej_d  = rej_q;
        if (state_q == S_ISSUE) begin
            sent_d[gnt_q] = sat_inc(sent_q[gnt_q]);
        end
        if (state_q == S_REJECT) begin
            rej_d = sat_inc(rej_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sent_q <= '{default: '0};
            rej_q  <= '0;
        end else begin
            sent_q <= sent_d;
            rej_q  <= rej_d;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        assign sent_cnt[i*STATS_CNT_W +: STATS_CNT_W] = sent_q[i];
    end
    assign reject_cnt = rej_q;
`endif

endmodule

// File: tb/tb_pck_inj_scheduler.sv
module tb_pck_inj_scheduler;
    localparam int NREQ     = 4;
    localparam int V        = 2;
    localparam int EAw      = 4;
    localparam int DATAw    = 128;
    localparam int PCK_SIZw = 5;

    logic clk;
    logic reset;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*EAw-1:0]      req_dest;
    logic [NREQ*PCK_SIZw-1:0] req_size;
    logic [NREQ*DATAw-1:0]    req_data;
    logic [NREQ*V-1:0]        req_vc;
    logic [NREQ-1:0]          req_ack;
    logic [NREQ-1:0]          req_err;
    logic                     busy;
`ifdef PCK_SCHED_STATS_EN
    logic [NREQ*16-1:0]       sent_cnt;
    logic [15:0]              reject_cnt;
`endif

    pck_inj_scheduler_if #(.V(V), .EAw(EAw), .DATAw(DATAw), .PCK_SIZw(PCK_SIZw)) inj_if ();

    pck_inj_scheduler #(.NREQ(NREQ), .V(V), .EAw(EAw), .DATAw(DATAw), .PCK_SIZw(PCK_SIZw),
                        .MIN_PCK_SIZE(3), .MAX_PCK_SIZE(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_dest  (req_dest),
        .req_size  (req_size),
        .req_data  (req_data),
        .req_vc    (req_vc),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .inj       (inj_if),
        .busy      (busy)
`ifdef PCK_SCHED_STATS_EN
        ,
        .sent_cnt  (sent_cnt),
        .reject_cnt(reject_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    // ---------------- behavioural reference model ----------------
    // The scheduler is modelled as a resource that is blocked for a number
    // of cycles after each grant: 2 after a write (write + gap), 1 after a
    // rejection. While free, the first eligible requester at or after the
    // round-robin position wins.
    logic [NREQ-1:0]     e_ack, e_err;
    logic                e_wr, e_busy;
    logic [EAw-1:0]      e_dest;
    logic [PCK_SIZw-1:0] e_size;
    logic [DATAw-1:0]    e_data;
    logic [V-1:0]        e_vc;
    int                  m_left, m_ptr, m_rej;
    int                  m_sent [NREQ];

    function automatic bit m_bad(input int i);
        logic [V-1:0] vc;
        int sz;
        vc = req_vc[i*V +: V];
        sz = int'(req_size[i*PCK_SIZw +: PCK_SIZw]);
        return ($countones(vc) != 1) || (sz < 3) || (sz > 20);
    endfunction

    function automatic bit m_elig(input int i);
        return req_valid[i] && (m_bad(i) || ((req_vc[i*V +: V] & inj_if.inj_ready) != 0));
    endfunction

    always @(posedge clk or negedge reset) begin
        int g;
        bit bd;
        if (!reset) begin
            e_ack <= '0; e_err <= '0; e_wr <= 1'b0; e_busy <= 1'b0;
            e_dest <= '0; e_size <= '0; e_data <= '0; e_vc <= '0;
            m_left <= 0; m_ptr <= 0; m_rej <= 0;
            for (int i = 0; i < NREQ; i++) m_sent[i] <= 0;
        end else begin
            e_ack <= '0; e_err <= '0; e_wr <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                e_busy <= (m_left > 1);
            end else begin
                g = -1;
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && m_elig((m_ptr + k) % NREQ)) g = (m_ptr + k) % NREQ;
                if (g >= 0) begin
                    bd = m_bad(g);
                    e_ack[g] <= 1'b1;
                    e_err[g] <= bd;
                    e_wr     <= !bd;
                    e_busy   <= 1'b1;
                    e_dest   <= req_dest[g*EAw +: EAw];
                    e_size   <= req_size[g*PCK_SIZw +: PCK_SIZw];
                    e_data   <= req_data[g*DATAw +: DATAw];
                    e_vc     <= req_vc[g*V +: V];
                    m_left   <= bd ? 1 : 2;
                    m_ptr    <= (g + 1) % NREQ;
                    if (bd) m_rej <= m_rej + 1;
                    else    m_sent[g] <= m_sent[g] + 1;
                end else begin
                    e_busy <= 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en && reset) begin
            chk("pck_wr",   inj_if.inj_pck_wr,    e_wr);
            chk("req_ack",  req_ack,              e_ack);
            chk("req_err",  req_err,              e_err);
            chk("busy",     busy,                 e_busy);
            chk("endp",     inj_if.inj_endp_addr, e_dest);
            chk("size",     inj_if.inj_size,      e_size);
            chk("data",     inj_if.inj_data,      e_data);
            chk("vc",       inj_if.inj_vc,        e_vc);
`ifdef PCK_SCHED_STATS_EN
            for (int i = 0; i < NREQ; i++)
                chk($sformatf("sent_cnt%0d", i), sent_cnt[i*16 +: 16], 128'(m_sent[i]));
            chk("reject_cnt", reject_cnt, 128'(m_rej));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic vld, input logic [EAw-1:0] d,
                           input logic [PCK_SIZw-1:0] s, input logic [V-1:0] vc,
                           input logic [DATAw-1:0] dat);
        req_valid[i]                 = vld;
        req_dest[i*EAw +: EAw]       = d;
        req_size[i*PCK_SIZw +: PCK_SIZw] = s;
        req_vc[i*V +: V]             = vc;
        req_data[i*DATAw +: DATAw]   = dat;
    endtask

    task automatic rand_req(input int i, input logic vld);
        logic [PCK_SIZw-1:0] s;
        logic [V-1:0] vc;
        if ($urandom_range(0, 9) != 0) s = PCK_SIZw'($urandom_range(3, 20));
        else if ($urandom_range(0, 1) == 0) s = PCK_SIZw'($urandom_range(0, 2));
        else s = PCK_SIZw'($urandom_range(21, 31));
        if ($urandom_range(0, 9) != 0) vc = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        else vc = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        set_req(i, vld, EAw'($urandom), s, vc, {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); #2 reset = 1'b0;
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for the next ack; a timeout shows up as an ack mismatch.
    task automatic expect_grant(input string nm, input logic [NREQ-1:0] exp_ack,
                                input logic exp_err, output int waited);
        waited = 0;
        while (waited < 10) begin
            @(negedge clk);
            waited++;
            if (req_ack != 0) break;
        end
        chk({nm, "_ack"},   req_ack,           exp_ack);
        chk({nm, "_model"}, e_ack,             exp_ack);
        chk({nm, "_err"},   |req_err,          exp_err);
        chk({nm, "_wr"},    inj_if.inj_pck_wr, !exp_err);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w;
        reset = 1'b0;
        req_valid = '0; req_dest = '0; req_size = '0; req_data = '0; req_vc = '0;
        inj_if.inj_ready = '0;
        idle(2);
        chk("rst_wr",   inj_if.inj_pck_wr, 1'b0);
        chk("rst_ack",  req_ack,           '0);
        chk("rst_busy", busy,              1'b0);
        chk("rst_size", inj_if.inj_size,   '0);
        chk("rst_data", inj_if.inj_data,   '0);
        #2 reset = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Single request from requester 2.
        inj_if.inj_ready = 2'b01;
        set_req(2, 1'b1, 4'd0, 5'd5, 2'b01, 128'h1234_5678);
        expect_grant("single", 4'b0100, 1'b0, w);
        chk("single_latency", w, 1);
        chk("single_size", inj_if.inj_size, 5);
        chk("single_data", inj_if.inj_data, 128'h1234_5678);
        set_req(2, 1'b0, 4'd0, 5'd5, 2'b01, 128'h1234_5678);
        idle(4);

        // Fairness: all requesters valid, all VCs ready.
        do_reset();
        inj_if.inj_ready = 2'b11;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, EAw'(i + 4), PCK_SIZw'(i + 3), (i % 2 == 0) ? 2'b01 : 2'b10, 128'(i * 1000 + 7));
        expect_grant("fair0", 4'b0001, 1'b0, w); chk("fair0_lat", w, 1);
        expect_grant("fair1", 4'b0010, 1'b0, w); chk("fair1_gap", w, 3);
        expect_grant("fair2", 4'b0100, 1'b0, w); chk("fair2_gap", w, 3);
        expect_grant("fair3", 4'b1000, 1'b0, w); chk("fair3_gap", w, 3);
        expect_grant("fair4", 4'b0001, 1'b0, w); chk("fair4_gap", w, 3);
        req_valid = '0;
        idle(4);

        // VC blocking: requester 0 waits for VC1.
        inj_if.inj_ready = 2'b01;
        set_req(0, 1'b1, 4'd9, 5'd8, 2'b10, 128'hA0);
        set_req(1, 1'b1, 4'd3, 5'd4, 2'b01, 128'hB1);
        expect_grant("vcblk1", 4'b0010, 1'b0, w);
        req_valid[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("vcblk_held", req_ack, '0);
        end
        inj_if.inj_ready = 2'b11;
        expect_grant("vcblk0", 4'b0001, 1'b0, w);
        chk("vcblk0_vc", inj_if.inj_vc, 2'b10);
        req_valid[0] = 1'b0;
        idle(4);

        // Illegal sizes are rejected even with no VC ready; pointer moves on.
        inj_if.inj_ready = 2'b00;
        set_req(2, 1'b1, 4'd1, 5'd2, 2'b01, 128'hC2);
        expect_grant("rej_sz2", 4'b0100, 1'b1, w);
        set_req(2, 1'b1, 4'd1, 5'd21, 2'b01, 128'hC3);
        expect_grant("rej_sz21", 4'b0100, 1'b1, w);
        chk("rej_spacing", w, 2);
        req_valid[2] = 1'b0;
        inj_if.inj_ready = 2'b11;
        set_req(1, 1'b1, 4'd5, 5'd3, 2'b01, 128'hD1);
        set_req(3, 1'b1, 4'd6, 5'd20, 2'b10, 128'hD3);
        expect_grant("rej_ptr3", 4'b1000, 1'b0, w);
        req_valid[3] = 1'b0;
        expect_grant("rej_ptr1", 4'b0010, 1'b0, w);
        req_valid[1] = 1'b0;
        idle(4);

        // Reset during GAP clears everything and the pointer.
        set_req(1, 1'b1, 4'd7, 5'd9, 2'b01, 128'hE1);
        expect_grant("mid_issue", 4'b0010, 1'b0, w);
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, 4'd2, 5'd6, 2'b01, 128'hF0);
        set_req(3, 1'b1, 4'd8, 5'd7, 2'b01, 128'hF3);
        @(negedge clk);
        chk("mid_gap_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_wr",   inj_if.inj_pck_wr,    1'b0);
        chk("mid_rst_busy", busy,                 1'b0);
        chk("mid_rst_ack",  req_ack,              '0);
        chk("mid_rst_size", inj_if.inj_size,      '0);
        chk("mid_rst_endp", inj_if.inj_endp_addr, '0);
        chk("mid_rst_vc",   inj_if.inj_vc,        '0);
        @(negedge clk); #2 reset = 1'b1;
        expect_grant("mid_after", 4'b0001, 1'b0, w);
        req_valid = '0;
        idle(4);

`ifdef PCK_SCHED_STATS_EN
        do_reset();
        inj_if.inj_ready = 2'b11;
        for (int p = 0; p < 10; p++) begin
            set_req(1, 1'b1, 4'd3, 5'd10, 2'b01, 128'(p));
            expect_grant("stat_send", 4'b0010, 1'b0, w);
        end
        for (int p = 0; p < 2; p++) begin
            set_req(1, 1'b1, 4'd3, 5'd0, 2'b01, 128'(p));
            expect_grant("stat_rej", 4'b0010, 1'b1, w);
        end
        req_valid = '0;
        idle(3);
        chk("stat_sent1", sent_cnt[16 +: 16], 16'd10);
        chk("stat_rejc",  reject_cnt,         16'd2);
`endif

        // Randomized traffic; requesters hold until acked.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c == 2000) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end
            inj_if.inj_ready = V'($urandom_range(0, 3));
            for (int i = 0; i < NREQ; i++) begin
                if (e_ack[i])
                    rand_req(i, $urandom_range(0, 9) < 7);
                else if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    rand_req(i, 1'b1);
            end
        end
        req_valid = '0;
        idle(5);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
